// File: rtl/debug_abstract_cmd_encoder_pkg.sv
// Shared types, RV32 encoding constants and instruction encoders for the debug abstract command encoder.
package debug_abstract_cmd_encoder_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_ADDI   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;

  localparam logic [15:0] REGNO_CSR_LAST  = 16'h0FFF;
  localparam logic [15:0] REGNO_GPR_FIRST = 16'h1000;
  localparam logic [15:0] REGNO_GPR_LAST  = 16'h101F;

  localparam int STEP_W = 3;

  typedef struct packed {
    logic        write;
    logic [15:0] regno;
    logic [31:0] data;
  } abstract_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_csr(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [11:0] csr, input logic [4:0] rs1);
    return enc_i(OP_SYSTEM, f3, rd, rs1, csr);
  endfunction

  // Upper immediate pre-compensated for the sign extension ADDI applies to the low 12 bits.
  function automatic logic [19:0] lui_hi(input logic [31:0] data);
    return data[31:12] + {19'd0, data[11]};
  endfunction

endpackage

// File: rtl/debug_instr_sequencer_rom.sv
// Maps (command, step) to the instruction for that step, plus the sequence's last and restore step indices.
module debug_instr_sequencer_rom
  import debug_abstract_cmd_encoder_pkg::*;
#(
  parameter int          TEMP_REG      = 8,
  parameter logic [11:0] DSCRATCH_ADDR = 12'h7B2
) (
  input  logic [STEP_W-1:0] step,
  input  abstract_cmd_t     cmd,
  output logic [31:0]       instr,
  output logic              last_step,
  output logic [STEP_W-1:0] restore_step,
  output logic              is_csr
);
  localparam logic [4:0] T = 5'(TEMP_REG);

  logic        is_gpr;
  logic [4:0]  gpr;
  logic [11:0] csr;
  logic [19:0] hi;
  logic [11:0] lo;
  logic [31:0] swap;

  assign is_gpr = (cmd.regno[15:5] == REGNO_GPR_FIRST[15:5]);
  assign gpr    = cmd.regno[4:0];
  assign csr    = cmd.regno[11:0];
  assign hi     = lui_hi(cmd.data);
  assign lo     = cmd.data[11:0];
  assign swap   = enc_csr(F3_CSRRW, T, DSCRATCH_ADDR, T);

  always_comb begin
    instr        = '0;
    last_step    = 1'b0;
    restore_step = '0;
    is_csr       = !is_gpr;
    case ({is_gpr, cmd.write})
      2'b11: begin
        instr     = (step == 3'd0) ? enc_u(OP_LUI, gpr, hi) : enc_i(OP_IMM, F3_ADDI, gpr, gpr, lo);
        last_step = (step == 3'd1);
      end
      2'b10: begin
        instr     = enc_csr(F3_CSRRW, 5'd0, DSCRATCH_ADDR, gpr);
        last_step = 1'b1;
      end
      2'b01: begin
        restore_step = 3'd4;
        last_step    = (step == 3'd4);
        case (step)
          3'd0:    instr = swap;
          3'd1:    instr = enc_u(OP_LUI, T, hi);
          3'd2:    instr = enc_i(OP_IMM, F3_ADDI, T, T, lo);
          3'd3:    instr = enc_csr(F3_CSRRW, 5'd0, csr, T);
          default: instr = swap;
        endcase
      end
      default: begin
        restore_step = 3'd2;
        last_step    = (step == 3'd2);
        case (step)
          3'd0:    instr = swap;
          3'd1:    instr = enc_csr(F3_CSRRS, T, csr, 5'd0);
          default: instr = swap;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/debug_abstract_cmd_encoder.sv
// Turns debug abstract register-access commands into RV32 instruction streams and reports completion.
module debug_abstract_cmd_encoder
  import debug_abstract_cmd_encoder_pkg::*;
#(
  parameter int          TEMP_REG        = 8,
  parameter logic [11:0] DSCRATCH_ADDR   = 12'h7B2,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_regno,
  input  logic [31:0] cmd_data,
  output logic        cmd_done,
  output logic        cmd_err,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  input  logic        instr_retired,
  input  logic        instr_exception
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

  state_t            state;
  abstract_cmd_t     cmd_q;
  abstract_cmd_t     cmd_in;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] step_adv;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     out_n;
  logic              err;
  logic              hs;
  logic              retire;
  logic              retire_exc;
  logic              unsupported;
  logic              x0_write;
  logic [31:0]       rom_instr;
  logic              rom_last;
  logic [STEP_W-1:0] rom_restore;
  logic              rom_is_csr;

  debug_instr_sequencer_rom #(
    .TEMP_REG      (TEMP_REG),
    .DSCRATCH_ADDR (DSCRATCH_ADDR)
  ) u_rom (
    .step         (step),
    .cmd          (cmd_q),
    .instr        (rom_instr),
    .last_step    (rom_last),
    .restore_step (rom_restore),
    .is_csr       (rom_is_csr)
  );

  // instr_valid/instr hold until instr_ready; the only exception is an instr_exception
  // redirect, which withdraws an unaccepted instruction in favour of the restore swap or nothing.
  assign instr       = instr_valid ? rom_instr : '0;
  assign cmd_err     = err;
  assign cmd_in      = {cmd_write, cmd_regno, cmd_data};
  assign unsupported = (cmd_regno > REGNO_GPR_LAST);
  assign x0_write    = cmd_write && (cmd_regno == REGNO_GPR_FIRST);
  assign hs          = instr_valid && instr_ready;
  assign retire      = (instr_retired || instr_exception) && (outstanding != '0);
  assign retire_exc  = instr_exception && (outstanding != '0);
  assign out_n       = outstanding + OW'(hs) - OW'(retire);
  assign step_adv    = hs ? step + 3'd1 : step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cmd_q       <= '0;
      step        <= '0;
      outstanding <= '0;
      err         <= 1'b0;
      instr_valid <= 1'b0;
      cmd_ready   <= 1'b1;
      cmd_done    <= 1'b0;
    end else begin
      outstanding <= out_n;
      cmd_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_q     <= cmd_in;
            err       <= unsupported;
            step      <= '0;
            cmd_ready <= 1'b0;
            if (unsupported || x0_write) begin
              state    <= ST_DONE;
              cmd_done <= 1'b1;
            end else begin
              state       <= ST_EMIT;
              instr_valid <= (out_n < MAX_CNT);
            end
          end
        end
        ST_EMIT: begin
          if (retire_exc) err <= 1'b1;
          if (hs && rom_last) begin
            state       <= ST_DRAIN;
            step        <= step_adv;
            instr_valid <= 1'b0;
          end else if (retire_exc) begin
            // Once the temp GPR is parked in DSCRATCH, it must be swapped back.
            if (rom_is_csr && (step_adv != '0)) begin
              step        <= rom_restore;
              instr_valid <= (out_n < MAX_CNT);
            end else begin
              state       <= ST_DRAIN;
              instr_valid <= 1'b0;
            end
          end else begin
            step        <= step_adv;
            instr_valid <= (out_n < MAX_CNT);
          end
        end
        ST_DRAIN: begin
          if (retire_exc) err <= 1'b1;
          if (outstanding == '0) begin
            state    <= ST_DONE;
            cmd_done <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
